pos_ring_inject_ctrl: RTL and testbench
=======================================

Name: pos_ring_inject_ctrl

Overview:
- Per-node scheduler that sequences fresh local particles from the position cache into the position ring input router.
- Walks the local cell's particle addresses and offers one particle at a time as the router's local valid/dirty pair.
- Predicts router acceptance so that no particle is injected twice, and cross-checks the router's dirty feedback.
- After the last injection it waits for the ring to drain, then signals end of iteration.

Parameters:
ADDR_WIDTH, 7, position cache address width (max 128 particles per cell)
NB_CELL_COUNT_WIDTH, 5, ring slot lifetime width (same as MD_pkg)
DRAIN_CYCLES, 16, consecutive empty-slot cycles required to declare the ring drained (at least the ring length)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  single-cycle pulse that begins an iteration
i_num_particles  in  ADDR_WIDTH+1  local particle count; latched on an accepted i_start
i_slot_lifetime  in  NB_CELL_COUNT_WIDTH  lifetime of the slot currently presented to the router (its source lifetime)
i_dispatcher_back_pressure  in  1  same signal the router sees
i_dirty_feedback  in  1  router's registered dirty feedback
o_rd_addr  out  ADDR_WIDTH  position cache read address
o_rd_en  out  1  position cache read enable
o_local_valid  out  1  local particle data is valid at the router
o_local_dirty  out  1  currently offered particle has already been injected
o_busy  out  1  high in every state except IDLE
o_done  out  1  single-cycle pulse at end of iteration
o_inject_count  out  ADDR_WIDTH+1  particles injected in this iteration
o_err  out  1  sticky feedback-mismatch flag; cleared only by rst

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, internal counters 0. Reset mid-operation aborts the iteration immediately, with no o_done.
- The position cache read is registered: data for o_rd_addr is valid one cycle after o_rd_en.
- accept = o_local_valid & ~o_local_dirty & ~i_dispatcher_back_pressure & (i_slot_lifetime == 0). This is exactly the router's injection condition and is computed combinationally from registered outputs.
- States:
  - IDLE:
    - Leave on i_start.
    - If i_num_particles == 0: go to DRAIN.
    - Otherwise: latch the count, set o_rd_addr = 0, o_rd_en = 1, go to FETCH.
    - i_start in any other state is ignored.
  - FETCH (1 cycle): o_rd_en = 0; go to OFFER with o_local_valid = 1 and o_local_dirty = 0.
  - OFFER:
    - Hold o_local_valid = 1 until accept.
    - On accept, with o_inject_count + 1 < count: increment o_inject_count, increment o_rd_addr, assert o_rd_en, drop o_local_valid, go to FETCH.
    - On accept of the last particle: o_local_valid = 0, o_local_dirty = 1, go to DRAIN.
    - Back pressure or a busy slot (lifetime != 0) simply stalls in OFFER.
  - DRAIN:
    - An empty-cycle counter increments when i_slot_lifetime == 0 and clears otherwise.
    - When the counter reaches DRAIN_CYCLES-1 with the slot still empty, go to DONE.
  - DONE (1 cycle): o_done = 1, then IDLE. o_inject_count holds until the next i_start.
- Peak injection rate is 1 particle per 2 cycles (fixed FETCH bubble).
- Feedback check:
  - A register exp_fb <= accept.
  - Each cycle, if i_dirty_feedback != exp_fb, set o_err = 1 (sticky).
  - The check is disabled in the first cycle after rst.
- Width rule: the count compare is unsigned at ADDR_WIDTH+1 bits. A count of 2^ADDR_WIDTH is legal; o_rd_addr wraps only after the last fetch, which is never used.
- Simultaneous events: accept and back pressure are mutually exclusive by definition. i_start and rst in the same cycle: rst wins.

Decomposition:
- Add the following to MD_pkg:
  - typedef enum inj_state_t {IDLE, FETCH, OFFER, DRAIN, DONE}
  - constant DRAIN_CYCLES_DEFAULT
- Reuse the package's NB_CELL_COUNT_WIDTH.
- One natural sub-module: ring_drain_detector (the DRAIN_CYCLES consecutive-empty counter with a drained output), reusable by the force ring.

Test Plan:
- Basic run: count = 3, lifetime always 0, no back pressure → accepts at cycles 2, 4, 6 after start with o_rd_addr = 0, 1, 2; o_done exactly DRAIN_CYCLES cycles after the last accept; o_inject_count = 3; o_err = 0.
- Back pressure: count = 2, back pressure high for 5 cycles while in OFFER → o_local_valid held, no accept, o_rd_addr stays 0; injection resumes the cycle after back pressure drops.
- Busy ring: i_slot_lifetime = 4 for 10 cycles during OFFER, then 0 → no accept while non-zero. In DRAIN, a single non-zero lifetime restarts the drain count, delaying o_done by the elapsed empty cycles.
- Zero particles: i_num_particles = 0 → no o_rd_en; o_done after DRAIN_CYCLES empty cycles; o_inject_count = 0.
- Feedback mismatch: force i_dirty_feedback = 1 with no preceding accept → o_err = 1 next cycle and stays high through o_done; only rst clears it.
- Reset mid-run: assert rst in OFFER after 1 accept → next cycle all outputs 0 and IDLE, no o_done. A new i_start restarts from o_rd_addr = 0.

Source files
------------

// File: rtl/MD_pkg.sv
// Shared MD datapath definitions: ring geometry constants and the
// position-ring inject controller state encoding.
package MD_pkg;

    localparam int NB_CELL_COUNT_WIDTH  = 5;
    localparam int DRAIN_CYCLES_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        OFFER,
        DRAIN,
        DONE
    } inj_state_t;

endpackage

// File: rtl/ring_drain_detector.sv
// Counts consecutive empty ring slots while enabled; o_drained flags the cycle in
// which the DRAIN_CYCLES-th consecutive empty slot is observed.
module ring_drain_detector
    import MD_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_slot_empty,
    output logic o_drained
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DRAIN_CYCLES - 1);

    logic [CNT_W-1:0] empty_cnt_q;
    logic [CNT_W-1:0] empty_cnt_d;

    // Any busy slot, or leaving the enabled window, restarts the streak.
    always_comb begin
        empty_cnt_d = '0;
        if (i_enable && i_slot_empty) begin
            empty_cnt_d = (empty_cnt_q == LAST) ? empty_cnt_q : empty_cnt_q + 1'b1;
        end
        o_drained = i_enable && i_slot_empty && (empty_cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            empty_cnt_q <= '0;
        end else begin
            empty_cnt_q <= empty_cnt_d;
        end
    end

endmodule

// File: rtl/pos_ring_inject_ctrl.sv
// Sequences local particles from the position cache into the position ring router,
// predicting router acceptance and cross-checking the router's dirty feedback.
module pos_ring_inject_ctrl
    import MD_pkg::*;
#(
    parameter int ADDR_WIDTH          = 7,
    parameter int NB_CELL_COUNT_WIDTH = MD_pkg::NB_CELL_COUNT_WIDTH,
    parameter int DRAIN_CYCLES        = DRAIN_CYCLES_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic [ADDR_WIDTH:0]            i_num_particles,
    input  logic [NB_CELL_COUNT_WIDTH-1:0] i_slot_lifetime,
    input  logic                           i_dispatcher_back_pressure,
    input  logic                           i_dirty_feedback,
    output logic [ADDR_WIDTH-1:0]          o_rd_addr,
    output logic                           o_rd_en,
    output logic                           o_local_valid,
    output logic                           o_local_dirty,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [ADDR_WIDTH:0]            o_inject_count,
    output logic                           o_err
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    inj_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic                   rd_en_q, rd_en_d;
    logic                   local_valid_q, local_valid_d;
    logic                   local_dirty_q, local_dirty_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       inject_count_q, inject_count_d;
    logic                   exp_fb_q, exp_fb_d;
    logic                   chk_en_q, chk_en_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   drained;
    logic [CNT_W-1:0]       next_count;

    ring_drain_detector #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_drain (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (state_q == DRAIN),
        .i_slot_empty (i_slot_lifetime == '0),
        .o_drained    (drained)
    );

    // Mirrors the router's injection condition exactly, from registered outputs only.
    assign accept = local_valid_q & ~local_dirty_q & ~i_dispatcher_back_pressure
                  & (i_slot_lifetime == '0);
    assign next_count = inject_count_q + CNT_W'(1);

    always_comb begin
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        rd_en_d        = rd_en_q;
        local_valid_d  = local_valid_q;
        local_dirty_d  = local_dirty_q;
        count_d        = count_q;
        inject_count_d = inject_count_q;
        exp_fb_d       = accept;
        chk_en_d       = 1'b1;
        err_d          = err_q | (chk_en_q & (i_dirty_feedback != exp_fb_q));

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    inject_count_d = '0;
                    local_dirty_d  = 1'b0;
                    if (i_num_particles == '0) begin
                        state_d = DRAIN;
                    end else begin
                        count_d   = i_num_particles;
                        rd_addr_d = '0;
                        rd_en_d   = 1'b1;
                        state_d   = FETCH;
                    end
                end
            end
            FETCH: begin
                rd_en_d       = 1'b0;
                local_valid_d = 1'b1;
                local_dirty_d = 1'b0;
                state_d       = OFFER;
            end
            OFFER: begin
                if (accept) begin
                    inject_count_d = next_count;
                    local_valid_d  = 1'b0;
                    if (next_count < count_q) begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        rd_en_d   = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        local_dirty_d = 1'b1;
                        state_d       = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rd_addr_q      <= '0;
            rd_en_q        <= 1'b0;
            local_valid_q  <= 1'b0;
            local_dirty_q  <= 1'b0;
            count_q        <= '0;
            inject_count_q <= '0;
            exp_fb_q       <= 1'b0;
            chk_en_q       <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_addr_q      <= rd_addr_d;
            rd_en_q        <= rd_en_d;
            local_valid_q  <= local_valid_d;
            local_dirty_q  <= local_dirty_d;
            count_q        <= count_d;
            inject_count_q <= inject_count_d;
            exp_fb_q       <= exp_fb_d;
            chk_en_q       <= chk_en_d;
            err_q          <= err_d;
        end
    end

    assign o_rd_addr      = rd_addr_q;
    assign o_rd_en        = rd_en_q;
    assign o_local_valid  = local_valid_q;
    assign o_local_dirty  = local_dirty_q;
    assign o_busy         = (state_q != IDLE);
    assign o_done         = (state_q == DONE);
    assign o_inject_count = inject_count_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_pos_ring_inject_ctrl.sv
// Bench for pos_ring_inject_ctrl: directed scenarios plus randomized runs, every cycle
// compared against a timestamp-based reference model of the injection rules.
module tb_pos_ring_inject_ctrl;

    localparam int AW = 7;
    localparam int CW = AW + 1;
    localparam int LW = 5;
    localparam int DC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          i_start;
    logic [CW-1:0] i_num_particles;
    logic [LW-1:0] i_slot_lifetime;
    logic          i_bp;
    logic          i_fb;
    logic [AW-1:0] o_rd_addr;
    logic          o_rd_en;
    logic          o_local_valid;
    logic          o_local_dirty;
    logic          o_busy;
    logic          o_done;
    logic [CW-1:0] o_inject_count;
    logic          o_err;

    pos_ring_inject_ctrl #(
        .ADDR_WIDTH          (AW),
        .NB_CELL_COUNT_WIDTH (LW),
        .DRAIN_CYCLES        (DC)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .i_start                    (i_start),
        .i_num_particles            (i_num_particles),
        .i_slot_lifetime            (i_slot_lifetime),
        .i_dispatcher_back_pressure (i_bp),
        .i_dirty_feedback           (i_fb),
        .o_rd_addr                  (o_rd_addr),
        .o_rd_en                    (o_rd_en),
        .o_local_valid              (o_local_valid),
        .o_local_dirty              (o_local_dirty),
        .o_busy                     (o_busy),
        .o_done                     (o_done),
        .o_inject_count             (o_inject_count),
        .o_err                      (o_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: which edge the next particle becomes visible, how many were
    // injected, and how long the current run of empty slots is.
    int cyc = 0;
    bit m_busy, m_drain, m_done, m_valid, m_dirty, m_rd_en, m_err, m_chk, m_fb;
    int m_inj = 0, m_total = 0, m_rd_addr = 0, m_run = 0, m_valid_at = -1;
    bit fb_force = 1'b0;

    assign i_fb = fb_force | m_fb;

    always @(posedge clk) begin : model
        bit acc;
        bit fb_seen;
        #1;
        fb_seen = i_fb;
        acc = m_valid && !i_bp && (i_slot_lifetime == 0);
        if (rst) begin
            m_busy = 0; m_drain = 0; m_done = 0; m_valid = 0; m_dirty = 0;
            m_rd_en = 0; m_err = 0; m_chk = 0; m_fb = 0;
            m_inj = 0; m_total = 0; m_rd_addr = 0; m_run = 0; m_valid_at = -1;
        end else begin
            if (m_chk && fb_seen != m_fb) m_err = 1;
            m_fb = acc;
            m_chk = 1;
            m_rd_en = 0;
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (i_start) begin
                    m_busy = 1; m_inj = 0; m_dirty = 0;
                    if (i_num_particles == 0) begin
                        m_drain = 1; m_run = 0;
                    end else begin
                        m_total = i_num_particles; m_rd_en = 1; m_rd_addr = 0;
                        m_valid_at = cyc + 1;
                    end
                end
            end else if (m_drain) begin
                m_run = (i_slot_lifetime == 0) ? m_run + 1 : 0;
                if (m_run == DC) begin
                    m_drain = 0; m_done = 1;
                end
            end else if (acc) begin
                m_inj++;
                m_valid = 0;
                if (m_inj < m_total) begin
                    m_rd_en = 1; m_rd_addr = m_inj; m_valid_at = cyc + 1;
                end else begin
                    m_dirty = 1; m_drain = 1; m_run = 0;
                end
            end else if (cyc == m_valid_at) begin
                m_valid = 1;
            end
        end
        cyc++;
        check("busy", o_busy, m_busy);
        check("done", o_done, m_done);
        check("valid", o_local_valid, m_valid);
        check("dirty", o_local_dirty, m_dirty);
        check("rd_en", o_rd_en, m_rd_en);
        check("rd_addr", o_rd_addr, m_rd_addr);
        check("inject_count", o_inject_count, m_inj);
        check("err", o_err, m_err);
    end

    task automatic idle_cycle();
        @(negedge clk);
        i_start = 0; i_slot_lifetime = 0; i_bp = 0;
    endtask

    task automatic launch(input int n);
        @(negedge clk);
        i_start = 1; i_num_particles = CW'(n); i_slot_lifetime = 0; i_bp = 0;
    endtask

    // Waits for o_done with an idle ring; one busy slot is presented at edge busy_at.
    task automatic wait_done(input int max, input int busy_at, output int lat);
        lat = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (o_done) begin
                lat = k;
                break;
            end
            i_start = 0; i_bp = 0;
            i_slot_lifetime = (k == busy_at) ? LW'(4) : LW'(0);
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        rst = 1; i_start = 0; i_num_particles = 0; i_slot_lifetime = 0; i_bp = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_local_valid, 0);
        check("rst_rd_en", o_rd_en, 0);
        check("rst_count", o_inject_count, 0);
        check("rst_err", o_err, 0);
        rst = 0;
        repeat (2) idle_cycle();

        launch(3);
        wait_done(200, -1, lat);
        check("basic_lat", lat, DC + 7);
        check("basic_cnt", o_inject_count, 3);
        check("basic_err", o_err, 0);

        idle_cycle();
        launch(2);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            i_start = 0; i_bp = 1;
        end
        @(negedge clk);
        check("bp_hold_valid", o_local_valid, 1);
        check("bp_hold_addr", o_rd_addr, 0);
        check("bp_hold_cnt", o_inject_count, 0);
        i_bp = 0;
        wait_done(200, -1, lat);
        check("bp_lat", lat, DC + 3);
        check("bp_cnt", o_inject_count, 2);

        idle_cycle();
        launch(1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            i_start = 0; i_slot_lifetime = 4;
        end
        @(negedge clk);
        check("busy_hold_valid", o_local_valid, 1);
        check("busy_hold_cnt", o_inject_count, 0);
        i_slot_lifetime = 0;
        wait_done(200, -1, lat);
        check("busy_lat", lat, DC + 1);

        idle_cycle();
        launch(0);
        wait_done(200, -1, lat);
        check("zero_lat", lat, DC + 1);
        check("zero_cnt", o_inject_count, 0);

        idle_cycle();
        launch(0);
        wait_done(200, 6, lat);
        check("drain_restart_lat", lat, DC + 7);

        idle_cycle();
        @(negedge clk);
        fb_force = 1;
        @(negedge clk);
        fb_force = 0;
        check("fb_err_set", o_err, 1);
        idle_cycle();
        launch(0);
        wait_done(200, -1, lat);
        check("fb_err_at_done", o_err, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("fb_err_cleared", o_err, 0);

        launch(5);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            i_start = 0;
        end
        @(negedge clk);
        check("mid_cnt_before", o_inject_count, 1);
        check("mid_valid_before", o_local_valid, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_valid", o_local_valid, 0);
        check("mid_rst_cnt", o_inject_count, 0);
        check("mid_rst_addr", o_rd_addr, 0);
        check("mid_rst_done", o_done, 0);
        repeat (2) idle_cycle();
        launch(2);
        wait_done(200, -1, lat);
        check("restart_lat", lat, DC + 5);
        check("restart_cnt", o_inject_count, 2);

        for (int it = 0; it < 40; it++) begin
            int bp_pct, lt_pct, n, rst_at;
            bit did_rst, finished;
            bp_pct = $urandom_range(50);
            lt_pct = $urandom_range(8);
            n = (it == 20) ? 128 : $urandom_range(12);
            rst_at = ($urandom_range(7) == 0) ? $urandom_range(1, 40) : -1;
            did_rst = 0;
            finished = 0;
            idle_cycle();
            launch(n);
            for (int k = 1; k <= 3000; k++) begin
                @(negedge clk);
                if (o_done || !o_busy) begin
                    finished = 1;
                    break;
                end
                rst = (k == rst_at);
                if (k == rst_at) did_rst = 1;
                i_start = ($urandom_range(99) < 3);
                i_num_particles = CW'($urandom_range(128));
                i_bp = ($urandom_range(99) < bp_pct);
                i_slot_lifetime = ($urandom_range(99) < lt_pct) ? LW'($urandom_range(1, 31)) : LW'(0);
            end
            rst = 0;
            if (!finished) check("rand_timeout", 0, 1);
            if (finished && !did_rst) check("rand_cnt", o_inject_count, n);
        end

        repeat (2) idle_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
